// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, fetch FSM states and the default reset vector.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetchState_t;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Architectural program counter: load-enable register with synchronous active-low reset.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    logic [XLEN-1:0] pcReg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcReg <= RESET_PC;
        end else if (load) begin
            pcReg <= d;
        end
    end

    assign q = pcReg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, instruction held for decode until accepted.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            misalign_err,
`endif
    output logic [XLEN-1:0] fetch_count
);

    fetchState_t     stateReg;
    fetchState_t     stateNext;
    logic [XLEN-1:0] instrReg;
    logic [XLEN-1:0] fetchCountReg;
    logic            captureEn;
    logic            acceptEn;
    logic            pcLoad;
    logic            holdValid;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) uPcRegister (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pcLoad),
        .d     (next_pc),
        .q     (pc)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalignErrReg;
    logic misalignSet;

    // A trapped fetch parks in S_HOLD but never offers an instruction again.
    assign holdValid = (stateReg == S_HOLD) && !misalignErrReg;
    assign misalignSet = acceptEn && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalignErrReg <= 1'b0;
        end else if (misalignSet) begin
            misalignErrReg <= 1'b1;
        end
    end

    assign misalign_err = misalignErrReg;
`else
    assign holdValid = (stateReg == S_HOLD);
`endif

    always_comb begin
        stateNext = stateReg;
        captureEn = 1'b0;
        acceptEn  = 1'b0;
        pcLoad    = 1'b0;
        case (stateReg)
            S_REQ: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        captureEn = 1'b1;
                        stateNext = S_HOLD;
                    end else begin
                        stateNext = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    captureEn = 1'b1;
                    stateNext = S_HOLD;
                end
            end
            S_HOLD: begin
                if (holdValid && instr_ready) begin
                    acceptEn = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (next_pc[1:0] == 2'b00) begin
                        pcLoad    = 1'b1;
                        stateNext = S_REQ;
                    end
`else
                    pcLoad    = 1'b1;
                    stateNext = S_REQ;
`endif
                end
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg      <= S_REQ;
            instrReg      <= '0;
            fetchCountReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (captureEn) begin
                instrReg <= imem_rdata;
            end
            // Natural 32-bit wrap is the intended behaviour.
            if (acceptEn) begin
                fetchCountReg <= fetchCountReg + 32'd1;
            end
        end
    end

    assign imem_req    = (stateReg == S_REQ);
    assign imem_addr   = pc;
    assign instr       = instrReg;
    assign instr_valid = holdValid;
    assign fetch_count = fetchCountReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (misalign cases when FETCH_MISALIGN_CHECK_EN is defined).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        next_pc     = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        tick();
        // stale response during reset must not be captured
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        check("rst_pc",          pc,          32'h0);
        check("rst_instr",       {31'b0, instr_valid}, 32'h0);
        check("rst_instr_word",  instr,       32'h0);
        check("rst_fetch_count", fetch_count, 32'h0);

        // release, one idle cycle without grant
        rst_n       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        check("rel_req",  {31'b0, imem_req}, 32'h1);
        check("rel_pc",   pc,        32'h0);
        check("rel_addr", imem_addr, 32'h0);

        // same-cycle grant and response
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("fast_valid", {31'b0, instr_valid}, 32'h1);
        check("fast_instr", instr, 32'h0000_0013);
        check("fast_req",   {31'b0, imem_req}, 32'h0);

        // accept, sequential next pc
        instr_ready = 1'b1;
        next_pc     = 32'h0000_0004;
        tick();
        instr_ready = 1'b0;
        check("acc1_pc",    pc,          32'h4);
        check("acc1_count", fetch_count, 32'h1);
        check("acc1_addr",  imem_addr,   32'h4);
        check("acc1_req",   {31'b0, imem_req}, 32'h1);
        check("acc1_valid", {31'b0, instr_valid}, 32'h0);

        // grant at N, response at N+3
        imem_gnt   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("lat_req_n%0d", i),   {31'b0, imem_req},    32'h0);
            check($sformatf("lat_valid_n%0d", i), {31'b0, instr_valid}, 32'h0);
            if (i < 3) tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("lat_valid_n4", {31'b0, instr_valid}, 32'h1);
        check("lat_instr",    instr, 32'h0050_0093);

        // backpressure for 5 cycles while memory noise is present
        instr_ready = 1'b0;
        next_pc     = 32'h0000_0008;
        for (int i = 0; i < 5; i++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hFFFF_0000 + 32'(i);
            tick();
            check($sformatf("bp_instr_%0d", i), instr, 32'h0050_0093);
            check($sformatf("bp_pc_%0d", i),    pc,    32'h4);
            check($sformatf("bp_req_%0d", i),   {31'b0, imem_req},    32'h0);
            check($sformatf("bp_valid_%0d", i), {31'b0, instr_valid}, 32'h1);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        next_pc     = 32'h0000_0100;
        tick();
        instr_ready = 1'b0;
        check("branch_pc",    pc,          32'h100);
        check("branch_count", fetch_count, 32'h2);
        check("branch_req",   {31'b0, imem_req}, 32'h1);

        // reset while in S_WAIT, response arrives after release
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("wait_req", {31'b0, imem_req}, 32'h0);
        rst_n = 1'b0;
        tick();
        check("wrst_pc",    pc,          32'h0);
        check("wrst_count", fetch_count, 32'h0);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("stale_valid", {31'b0, instr_valid}, 32'h0);
        check("stale_instr", instr, 32'h0);
        check("stale_req",   {31'b0, imem_req}, 32'h1);
        check("stale_pc",    pc, 32'h0);

        // fetch once more and accept a misaligned target
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0067;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("mis_fetch_valid", {31'b0, instr_valid}, 32'h1);
        instr_ready = 1'b1;
        next_pc     = 32'h0000_0102;
        tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mis_err_%0d", i),   {31'b0, misalign_err}, 32'h1);
            check($sformatf("mis_pc_%0d", i),    pc, 32'h0);
            check($sformatf("mis_valid_%0d", i), {31'b0, instr_valid}, 32'h0);
            check($sformatf("mis_req_%0d", i),   {31'b0, imem_req},    32'h0);
            tick();
        end
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mis_err_clr", {31'b0, misalign_err}, 32'h0);
        check("mis_rst_req", {31'b0, imem_req},     32'h1);
`else
        instr_ready = 1'b0;
        check("unal_pc",    pc,          32'h102);
        check("unal_addr",  imem_addr,   32'h102);
        check("unal_count", fetch_count, 32'h1);
        check("unal_req",   {31'b0, imem_req}, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-cycle RV32I core. It holds the architectural program counter and drives it to `next_pc_logic`. It fetches the instruction at PC from instruction memory over a request/grant/response handshake and presents it to decode with a valid/ready handshake. When decode accepts an instruction, the unit loads PC from `next_pc_logic`'s `NextPC`.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `next_pc`  in  32  `NextPC` from `next_pc_logic`; sampled only on instruction acceptance.
- `pc`  out  32  current PC; feeds `next_pc_logic.PC` and decode.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  fetched instruction held for decode.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decode accepts `instr`.
- `fetch_count`  out  32  number of instructions accepted by decode.
- `misalign_err`  out  1  sticky misaligned-target flag; present only when `FETCH_MISALIGN_CHECK_EN` is defined.

## Operation
The state machine has three states: `S_REQ`, `S_WAIT`, `S_HOLD`.
- **`S_REQ`**: `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_gnt`=0: stay in `S_REQ`.
  - `imem_gnt`=1 and `imem_rvalid`=1 in the same cycle: capture `imem_rdata`, go to `S_HOLD`.
  - `imem_gnt`=1 only: go to `S_WAIT`.
- **`S_WAIT`**: `imem_req`=0. Wait for `imem_rvalid`; on it, capture `imem_rdata` into `instr` and go to `S_HOLD`.
- **`S_HOLD`**: `instr_valid`=1. `instr` and `pc` are stable until acceptance.
  - Acceptance is `instr_valid && instr_ready`. On acceptance: `pc`←`next_pc`, `fetch_count`+1, go to `S_REQ`.
- `imem_rvalid` outside `S_WAIT`, and outside the same-cycle grant case in `S_REQ`, is ignored. This includes stale responses after reset.
- `imem_req`, `imem_addr` and `instr_valid` are decoded from state and `pc` registers only; no combinational path from any input.
- `fetch_count` wraps from `32'hFFFF_FFFF` to 0.
- Only one request is outstanding at a time; no prefetch.

## Timing
- Reset values (any cycle with `rst_n`=0 at the clock edge):
  - `pc`=`RESET_PC`, state=`S_REQ`, `instr`=0, `fetch_count`=0, `misalign_err`=0.
  - `instr_valid`=0. `imem_req` is 1 from the first cycle after reset.
- Reset mid-operation aborts any outstanding request. The pending response is ignored, because state is `S_REQ` until the next grant.
- Minimum loop:
  - Cycle 0: `S_REQ`, grant and rvalid together.
  - Cycle 1: `S_HOLD`, `instr_valid`=1; if `instr_ready`=1, it is accepted.
  - Cycle 2: `S_REQ` with the new `pc`.
  - This gives 2 cycles per instruction.
- Each cycle of response latency after grant adds 1 cycle.
- Backpressure: `instr_ready`=0 holds `S_HOLD` indefinitely with no memory traffic.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - On acceptance, if `next_pc[1:0]`≠0, `misalign_err` sets to 1 and `pc` is not updated.
  - The state moves to `S_HOLD` with `instr_valid`=0. In this error case, `instr_valid` is 0 in `S_HOLD` even though the state is `S_HOLD`.
  - The unit stays there until reset.
  - `misalign_err` clears only on reset.
- Not defined:
  - The `misalign_err` port is absent.
  - `next_pc` is loaded unconditionally; bits [1:0] pass through to `imem_addr`.

## Structure
- `riscv_pkg` holds:
  - `XLEN`=32;
  - the fetch state enum (`S_REQ`, `S_WAIT`, `S_HOLD`);
  - the default reset vector constant used as the `RESET_PC` default.
- One sub-module, `pc_register`: a 32-bit load-enable register with synchronous active-low reset to `RESET_PC`, instantiated for `pc`.
- The state machine and `fetch_count` live in the top level.

## Test plan
- Reset then release, memory granting and responding same cycle with `32'h0000_0013`:
  - `pc`=0, `imem_req`=1 one cycle after release;
  - `instr`=`32'h0000_0013`, `instr_valid`=1 one cycle after grant.
- `instr_ready`=1 with `next_pc`=`32'h0000_0004` → next cycle `pc`=4, `fetch_count`=1, `imem_addr`=4.
- Grant at cycle N, `imem_rvalid` at N+3 → `instr_valid` at N+4; `imem_req` stays 0 during N+1..N+3.
- `instr_ready`=0 for 5 cycles in `S_HOLD`:
  - `instr` and `pc` are unchanged, `imem_req`=0;
  - acceptance on cycle 6 loads a branch target `next_pc`=`32'h0000_0100`.
- `rst_n`=0 while in `S_WAIT`, then `imem_rvalid` arrives the cycle after release:
  - the response is ignored; `pc`=`RESET_PC`, `instr_valid`=0.
- With `FETCH_MISALIGN_CHECK_EN`: acceptance with `next_pc`=`32'h0000_0102`:
  - `misalign_err`=1, `pc` is unchanged, `instr_valid` stays 0 until reset.
